// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between fetch (IF) and load/store (MEM); MEM has fixed priority.
// Each access: grant in IDLE, WAIT_CYCLES of ACCESS, one DONE cycle with the ready pulse; freeze stalls waiting requesters.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_grant_mem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sram_en;
  logic               r_sram_we;
  logic [ADDR_W-1:0]  r_sram_addr;
  logic [DATA_W-1:0]  r_sram_wdata;
  logic [DATA_W-1:0]  r_if_rdata;
  logic [DATA_W-1:0]  r_mem_rdata;
  logic               w_mem_req;
  logic               w_last;

  assign w_mem_req = mem_r_en | mem_w_en;
  assign w_last    = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_mem_req || if_req) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request fields are latched at grant so requesters may change them mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_mem  <= 1'b0;
      r_cnt        <= '0;
      r_sram_en    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_mem_req) begin
            r_grant_mem  <= 1'b1;
            r_sram_en    <= 1'b1;
            r_sram_we    <= mem_w_en;
            r_sram_addr  <= mem_addr;
            r_sram_wdata <= mem_wdata;
          end else if (if_req) begin
            r_grant_mem  <= 1'b0;
            r_sram_en    <= 1'b1;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= if_addr;
            r_sram_wdata <= '0;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sram_en <= 1'b0;
            r_sram_we <= 1'b0;
            if (r_grant_mem) begin
              r_mem_rdata <= r_sram_we ? '0 : sram_rdata;
            end else begin
              r_if_rdata <= sram_rdata;
            end
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign if_ready   = (r_state == S_DONE) & ~r_grant_mem;
  assign mem_ready  = (r_state == S_DONE) &  r_grant_mem;
  assign if_rdata   = r_if_rdata;
  assign mem_rdata  = r_mem_rdata;
  assign sram_en    = r_sram_en;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign freeze     = (if_req & ~if_ready) | (w_mem_req & ~mem_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: main instance at WAIT_CYCLES=4, second instance at WAIT_CYCLES=1.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        if_req, mem_r_en, mem_w_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, freeze, sram_en, sram_we;

  logic        b_if_req;
  logic [31:0] b_if_addr;
  logic [31:0] b_if_rdata, b_mem_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;
  logic        b_if_ready, b_mem_ready, b_freeze, b_sram_en, b_sram_we;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] sram_model(input logic [31:0] a);
    return (a == 32'h10) ? 32'hE3A00005 : (a ^ 32'hA5A50000);
  endfunction

  assign sram_rdata   = sram_model(sram_addr);
  assign b_sram_rdata = sram_model(b_sram_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_r_en(1'b0), .mem_w_en(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready), .freeze(b_freeze),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    mem_addr = '0; mem_wdata = '0; b_if_req = 1'b0; b_if_addr = '0;

    #12;
    check_val("rst_sram_en",   32'(sram_en),   32'h0);
    check_val("rst_sram_we",   32'(sram_we),   32'h0);
    check_val("rst_if_ready",  32'(if_ready),  32'h0);
    check_val("rst_mem_ready", 32'(mem_ready), 32'h0);
    check_val("rst_if_rdata",  if_rdata,       32'h0);
    check_val("rst_freeze",    32'(freeze),    32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Test 1: single fetch
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) if_req = 1'b0;
      @(negedge clk);
      check_val($sformatf("t1_en_c%0d", c),     32'(sram_en),  32'(c >= 1 && c <= 4));
      check_val($sformatf("t1_ready_c%0d", c),  32'(if_ready), 32'(c == 5));
      check_val($sformatf("t1_freeze_c%0d", c), 32'(freeze),   32'(c <= 4));
      if (c == 2) begin
        check_val("t1_addr", sram_addr, 32'h10);
        check_val("t1_we",   32'(sram_we), 32'h0);
      end
      if (c == 5) check_val("t1_rdata", if_rdata, 32'hE3A00005);
      next_cycle();
    end

    // Test 2: simultaneous IF and MEM load
    if_req = 1'b1; if_addr = 32'h20; mem_r_en = 1'b1; mem_addr = 32'h100;
    for (int c = 0; c < 13; c++) begin
      if (c == 6)  mem_r_en = 1'b0;
      if (c == 12) if_req = 1'b0;
      @(negedge clk);
      check_val($sformatf("t2_mready_c%0d", c), 32'(mem_ready), 32'(c == 5));
      check_val($sformatf("t2_iready_c%0d", c), 32'(if_ready),  32'(c == 11));
      if (c == 2) check_val("t2_addr_mem", sram_addr, 32'h100);
      if (c == 8) check_val("t2_addr_if",  sram_addr, 32'h20);
      if (c == 5) begin
        check_val("t2_mem_rdata",  mem_rdata, 32'hA5A50100);
        check_val("t2_if_hold",    if_rdata,  32'hE3A00005);
        check_val("t2_freeze_c5",  32'(freeze), 32'h1);
      end
      if (c == 11) begin
        check_val("t2_if_rdata",   if_rdata,  32'hA5A50020);
        check_val("t2_mem_hold",   mem_rdata, 32'hA5A50100);
        check_val("t2_freeze_c11", 32'(freeze), 32'h0);
      end
      next_cycle();
    end

    // Test 3: store, address changed mid-access
    mem_w_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin mem_addr = 32'h44; mem_wdata = 32'h11111111; end
      if (c == 6) mem_w_en = 1'b0;
      @(negedge clk);
      check_val($sformatf("t3_we_c%0d", c),    32'(sram_we),   32'(c >= 1 && c <= 4));
      check_val($sformatf("t3_ready_c%0d", c), 32'(mem_ready), 32'(c == 5));
      if (c >= 1 && c <= 4) begin
        check_val($sformatf("t3_addr_c%0d", c),  sram_addr,  32'h40);
        check_val($sformatf("t3_wdata_c%0d", c), sram_wdata, 32'hDEADBEEF);
      end
      if (c == 5) check_val("t3_rdata", mem_rdata, 32'h0);
      next_cycle();
    end

    // Test 6: load and store together behave as a store
    mem_r_en = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h50; mem_wdata = 32'h12345678;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
      @(negedge clk);
      check_val($sformatf("t6_we_c%0d", c),    32'(sram_we),   32'(c >= 1 && c <= 4));
      check_val($sformatf("t6_ready_c%0d", c), 32'(mem_ready), 32'(c == 5));
      if (c == 3) check_val("t6_wdata", sram_wdata, 32'h12345678);
      if (c == 5) check_val("t6_rdata", mem_rdata, 32'h0);
      next_cycle();
    end

    // Test 4: reset during the second ACCESS cycle
    if_req = 1'b1; if_addr = 32'h10;
    next_cycle();
    next_cycle();
    rst = 1'b1; if_req = 1'b0;
    #1;
    check_val("t4_en_in_rst",    32'(sram_en),  32'h0);
    check_val("t4_ready_in_rst", 32'(if_ready), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_val($sformatf("t4_noready_c%0d", c), 32'(if_ready), 32'h0);
      check_val($sformatf("t4_noen_c%0d", c),    32'(sram_en),  32'h0);
      next_cycle();
    end
    if_req = 1'b1; if_addr = 32'h30;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) if_req = 1'b0;
      @(negedge clk);
      check_val($sformatf("t4_rr_ready_c%0d", c), 32'(if_ready), 32'(c == 5));
      if (c == 5) check_val("t4_rr_rdata", if_rdata, 32'hA5A50030);
      next_cycle();
    end

    // Test 5: WAIT_CYCLES=1, continuous fetch with a new address each grant
    b_if_req = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c % 3 == 0) b_if_addr = 32'h100 + 32'(4 * (c / 3));
      @(negedge clk);
      check_val($sformatf("t5_ready_c%0d", c), 32'(b_if_ready), 32'(c % 3 == 2));
      check_val($sformatf("t5_en_c%0d", c),    32'(b_sram_en),  32'(c % 3 == 1));
      if (c % 3 == 1)
        check_val($sformatf("t5_addr_c%0d", c), b_sram_addr, 32'h100 + 32'(4 * (c / 3)));
      if (c % 3 == 2) begin
        check_val($sformatf("t5_rdata_c%0d", c), b_if_rdata,
                  (32'h100 + 32'(4 * (c / 3))) ^ 32'hA5A50000);
        check_val($sformatf("t5_freeze_c%0d", c), 32'(b_freeze), 32'h0);
      end
      next_cycle();
    end
    b_if_req = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
